// File: rtl/microwave_pkg.sv
// Shared types and segment codes for the microwave controller.
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    // Segment order {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

endpackage

// File: rtl/microwave_controller_seg7_decoder.sv
// BCD digit to 7-segment code; non-BCD values go dark.
module seg7_decoder
    import microwave_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        unique case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/microwave_controller.sv
// Microwave controller: keypad M:SS entry, 1 Hz countdown, door interlock.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits on the display.
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int CLK_HZ = 100
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [6:0] mins_seg,
    output logic [6:0] sec_tens_seg,
    output logic [6:0] sec_ones_seg,
    output logic       mag_on
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);

    state_t        r_state;
    bcd_t          r_mins;
    bcd_t          r_tens;
    bcd_t          r_ones;
    logic [PW-1:0] r_pre;
    logic          r_key_prev;
    logic          r_mag;

    bcd_t w_digit;
    logic w_key_any;
    logic w_press;
    logic w_nonzero;
    logic w_start_ok;
    logic w_hold;
    logic w_wrap;
    logic w_last;

    // Later bits overwrite earlier ones, so the highest key wins.
    always_comb begin
        w_digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) w_digit = bcd_t'(i);
        end
    end

    assign w_key_any  = |keypad;
    assign w_press    = w_key_any && !r_key_prev;
    assign w_nonzero  = (r_mins != 0) || (r_tens != 0) || (r_ones != 0);
    assign w_start_ok = !startn && stopn && door_closed && w_nonzero;
    assign w_hold     = !stopn || !door_closed;
    assign w_wrap     = (r_pre == PRE_TC);
    assign w_last     = (r_mins == 0) && (r_tens == 0) && (r_ones == 4'd1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_mins     <= '0;
            r_tens     <= '0;
            r_ones     <= '0;
            r_pre      <= '0;
            r_key_prev <= 1'b0;
            r_mag      <= 1'b0;
        end else begin
            r_key_prev <= w_key_any;
            if (!clearn) begin
                r_state <= IDLE;
                r_mins  <= '0;
                r_tens  <= '0;
                r_ones  <= '0;
                r_pre   <= '0;
                r_mag   <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_start_ok) begin
                            r_state <= COOK;
                            r_pre   <= '0;
                            r_mag   <= 1'b1;
                        end else if (w_press) begin
                            r_mins <= r_tens;
                            r_tens <= r_ones;
                            r_ones <= w_digit;
                        end
                    end
                    COOK: begin
                        if (w_hold) begin
                            r_state <= PAUSE;
                            r_mag   <= 1'b0;
                        end else if (w_wrap) begin
                            r_pre <= '0;
                            if (r_ones != 0) begin
                                r_ones <= r_ones - 4'd1;
                            end else if (r_tens != 0) begin
                                r_ones <= 4'd9;
                                r_tens <= r_tens - 4'd1;
                            end else begin
                                r_ones <= 4'd9;
                                r_tens <= 4'd5;
                                r_mins <= r_mins - 4'd1;
                            end
                            if (w_last) begin
                                r_state <= IDLE;
                                r_mag   <= 1'b0;
                            end
                        end else begin
                            r_pre <= r_pre + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (w_start_ok) begin
                            r_state <= COOK;
                            r_pre   <= '0;
                            r_mag   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_mag   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mag_on = r_mag;

    logic [6:0] w_mins_seg;
    logic [6:0] w_tens_seg;
    logic [6:0] w_ones_seg;

    seg7_decoder u_mins (.i_bcd(r_mins), .o_seg(w_mins_seg));
    seg7_decoder u_tens (.i_bcd(r_tens), .o_seg(w_tens_seg));
    seg7_decoder u_ones (.i_bcd(r_ones), .o_seg(w_ones_seg));

`ifdef LEADING_ZERO_BLANK_EN
    assign mins_seg     = (r_mins == 0) ? 7'h00 : w_mins_seg;
    assign sec_tens_seg = (r_mins == 0 && r_tens == 0) ? 7'h00 : w_tens_seg;
`else
    assign mins_seg     = w_mins_seg;
    assign sec_tens_seg = w_tens_seg;
`endif
    assign sec_ones_seg = w_ones_seg;

endmodule

// File: tb/tb_microwave_controller.sv
// Directed self-checking bench for microwave_controller.
module tb_microwave_controller;

    logic       clock;
    logic       resetn;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic [6:0] mins_seg;
    logic [6:0] sec_tens_seg;
    logic [6:0] sec_ones_seg;
    logic       mag_on;

    int total = 0;
    int bad   = 0;

    microwave_controller #(.CLK_HZ(100)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .keypad       (keypad),
        .startn       (startn),
        .stopn        (stopn),
        .clearn       (clearn),
        .door_closed  (door_closed),
        .mins_seg     (mins_seg),
        .sec_tens_seg (sec_tens_seg),
        .sec_ones_seg (sec_ones_seg),
        .mag_on       (mag_on)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [20:0] disp(input int m, input int t, input int o);
        return {seg_of(m), seg_of(t), seg_of(o)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input int d);
        logic [9:0] v;
        v = 10'd1 << d;
        keypad = v;
        tick(11);
        keypad = '0;
        tick(1);
    endtask

    task automatic start_btn();
        startn = 1'b0;
        tick(1);
        startn = 1'b1;
    endtask

    task automatic clear_btn();
        clearn = 1'b0;
        tick(1);
        clearn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(3);
        total++;
        if (mag_on !== 1'b0) begin
            bad++;
            $display("FAIL reset_mag got=%b exp=0", mag_on);
        end
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(0, 0, 0)) begin
            bad++;
            $display("FAIL reset_disp got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(0, 0, 0));
        end
        resetn = 1'b1;
        tick(2);
        press(3);
        press(5);
        press(9);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(3, 5, 9)) begin
            bad++;
            $display("FAIL entry_359 got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(3, 5, 9));
        end
    endtask

    task automatic test_door_start();
        door_closed = 1'b0;
        startn = 1'b0;
        tick(11);
        startn = 1'b1;
        total++;
        if (mag_on !== 1'b0 ||
            {mins_seg, sec_tens_seg, sec_ones_seg} !== disp(3, 5, 9)) begin
            bad++;
            $display("FAIL door_open_start mag=%b disp=%h exp mag=0 disp=%h",
                mag_on, {mins_seg, sec_tens_seg, sec_ones_seg}, disp(3, 5, 9));
        end
        door_closed = 1'b1;
        tick(1);
        start_btn();
        total++;
        if (mag_on !== 1'b1) begin
            bad++;
            $display("FAIL start_mag got=%b exp=1", mag_on);
        end
        tick(99);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(3, 5, 9)) begin
            bad++;
            $display("FAIL pre_first_dec got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(3, 5, 9));
        end
        tick(1);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(3, 5, 8)) begin
            bad++;
            $display("FAIL first_dec got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(3, 5, 8));
        end
        tick(23799);
        total++;
        if (mag_on !== 1'b1 ||
            {mins_seg, sec_tens_seg, sec_ones_seg} !== disp(0, 0, 1)) begin
            bad++;
            $display("FAIL at_001 mag=%b disp=%h exp mag=1 disp=%h",
                mag_on, {mins_seg, sec_tens_seg, sec_ones_seg}, disp(0, 0, 1));
        end
        tick(1);
        total++;
        if (mag_on !== 1'b0 ||
            {mins_seg, sec_tens_seg, sec_ones_seg} !== disp(0, 0, 0)) begin
            bad++;
            $display("FAIL done_000 mag=%b disp=%h exp mag=0 disp=%h",
                mag_on, {mins_seg, sec_tens_seg, sec_ones_seg}, disp(0, 0, 0));
        end
        press(2);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(0, 0, 2)) begin
            bad++;
            $display("FAIL idle_after_done got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(0, 0, 2));
        end
        clear_btn();
    endtask

    task automatic test_door_interlock();
        press(2);
        press(4);
        press(5);
        start_btn();
        tick(300);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(2, 4, 2)) begin
            bad++;
            $display("FAIL door_run3 got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(2, 4, 2));
        end
        door_closed = 1'b0;
        tick(1);
        total++;
        if (mag_on !== 1'b0) begin
            bad++;
            $display("FAIL door_open_mag got=%b exp=0", mag_on);
        end
        tick(150);
        startn = 1'b0;
        tick(5);
        startn = 1'b1;
        total++;
        if (mag_on !== 1'b0 ||
            {mins_seg, sec_tens_seg, sec_ones_seg} !== disp(2, 4, 2)) begin
            bad++;
            $display("FAIL door_frozen mag=%b disp=%h exp mag=0 disp=%h",
                mag_on, {mins_seg, sec_tens_seg, sec_ones_seg}, disp(2, 4, 2));
        end
        door_closed = 1'b1;
        start_btn();
        total++;
        if (mag_on !== 1'b1) begin
            bad++;
            $display("FAIL door_resume_mag got=%b exp=1", mag_on);
        end
        tick(99);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(2, 4, 2)) begin
            bad++;
            $display("FAIL door_resume_hold got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(2, 4, 2));
        end
        tick(1);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(2, 4, 1)) begin
            bad++;
            $display("FAIL door_resume_dec got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(2, 4, 1));
        end
        clear_btn();
    endtask

    task automatic test_stop_resume();
        press(2);
        press(4);
        press(5);
        start_btn();
        tick(300);
        stopn = 1'b0;
        tick(1);
        total++;
        if (mag_on !== 1'b0) begin
            bad++;
            $display("FAIL stop_mag got=%b exp=0", mag_on);
        end
        tick(20);
        stopn = 1'b1;
        tick(200);
        total++;
        if (mag_on !== 1'b0 ||
            {mins_seg, sec_tens_seg, sec_ones_seg} !== disp(2, 4, 2)) begin
            bad++;
            $display("FAIL stop_held mag=%b disp=%h exp mag=0 disp=%h",
                mag_on, {mins_seg, sec_tens_seg, sec_ones_seg}, disp(2, 4, 2));
        end
        start_btn();
        tick(100);
        total++;
        if (mag_on !== 1'b1 ||
            {mins_seg, sec_tens_seg, sec_ones_seg} !== disp(2, 4, 1)) begin
            bad++;
            $display("FAIL stop_resume mag=%b disp=%h exp mag=1 disp=%h",
                mag_on, {mins_seg, sec_tens_seg, sec_ones_seg}, disp(2, 4, 1));
        end
        clear_btn();
    endtask

    task automatic test_clear();
        press(2);
        press(4);
        press(5);
        start_btn();
        tick(300);
        press(7);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(2, 4, 2)) begin
            bad++;
            $display("FAIL key_in_cook got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(2, 4, 2));
        end
        clear_btn();
        total++;
        if (mag_on !== 1'b0 ||
            {mins_seg, sec_tens_seg, sec_ones_seg} !== disp(0, 0, 0)) begin
            bad++;
            $display("FAIL clear_cook mag=%b disp=%h exp mag=0 disp=%h",
                mag_on, {mins_seg, sec_tens_seg, sec_ones_seg}, disp(0, 0, 0));
        end
        startn = 1'b0;
        tick(5);
        startn = 1'b1;
        total++;
        if (mag_on !== 1'b0) begin
            bad++;
            $display("FAIL start_zero got=%b exp=0", mag_on);
        end
    endtask

    task automatic test_entry_borrow();
        press(1);
        press(7);
        press(9);
        press(2);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(7, 9, 2)) begin
            bad++;
            $display("FAIL entry_wrap got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(7, 9, 2));
        end
        keypad = 10'b00_0010_0100;
        tick(11);
        keypad = '0;
        tick(1);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(9, 2, 5)) begin
            bad++;
            $display("FAIL multi_key got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(9, 2, 5));
        end
        clear_btn();
        press(1);
        press(0);
        press(0);
        start_btn();
        tick(99);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(1, 0, 0)) begin
            bad++;
            $display("FAIL borrow_pre got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(1, 0, 0));
        end
        tick(1);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(0, 5, 9)) begin
            bad++;
            $display("FAIL borrow_min got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(0, 5, 9));
        end
        tick(900);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(0, 5, 0)) begin
            bad++;
            $display("FAIL count_050 got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(0, 5, 0));
        end
        tick(100);
        total++;
        if ({mins_seg, sec_tens_seg, sec_ones_seg} !== disp(0, 4, 9)) begin
            bad++;
            $display("FAIL borrow_tens got=%h exp=%h",
                {mins_seg, sec_tens_seg, sec_ones_seg}, disp(0, 4, 9));
        end
        clear_btn();
    endtask

    initial begin
        resetn      = 1'b0;
        keypad      = '0;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;
        test_reset();
        test_door_start();
        test_door_interlock();
        test_stop_resume();
        test_clear();
        test_entry_borrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
